lcd_page_buf: RTL and testbench
===============================

Name: lcd_page_buf

Overview:
- Responder side of the LCD data request/acknowledge handshake.
- On `data_request` it fetches one 8-row × 64-column strip of a row-major monochrome image from a synchronous-read image memory.
- It transposes the strip into 64 LCD column bytes (bit0 = top row), acknowledges, then serves the bytes in order on `data`, one per `byte_rd` strobe.
- Sits between the image ROM/RAM and the LCD controller.

Parameters:
- COLS, 64: columns per strip and bytes served per request. Fixed at 64; any other value is unsupported.
- MEM_AW, 10: image memory address width, {addr[6:0], row[2:0]}.

Ports:
- clk  input  1  block clock
- rst_n  input  1  asynchronous active-low reset
- data_request  input  1  level request from LCD controller
- addr  input  7  {image[3:0], page[2:0]} of the strip to fetch
- byte_rd  input  1  one-cycle strobe: controller has consumed current `data` byte
- data_ack  output  1  one-cycle pulse: strip ready, byte 0 on `data`
- data  output  8  current column byte
- busy  output  1  high in any state other than IDLE
- mem_rd  output  1  image memory read enable
- mem_addr  output  MEM_AW  image memory address
- mem_rdata  input  64  row data, valid 1 cycle after mem_rd; bit c = column c, 1 = pixel on

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data_ack=0, data=8'h00, busy=0, mem_rd=0, mem_addr=0; 64×8 buffer cleared; row_cnt=0, rd_ptr=0.
- States: IDLE, FETCH, DRAIN, ACK, SERVE.
- IDLE: when data_request=1 is sampled, latch addr into addr_q, set row_cnt=0, go to FETCH. byte_rd is ignored in IDLE.
- FETCH, 8 cycles: each cycle drives mem_rd=1 and mem_addr={addr_q,row_cnt}, then increments row_cnt. Row r is issued in FETCH cycle r (r=0..7).
- Capture: mem_rdata for row r is captured one cycle after issue. Rows 0-6 are captured in FETCH cycles 1-7; row 7 is captured in DRAIN.
  - Transpose rule: buf[c][r] = mem_rdata[c], for c=0..63.
- FETCH exits to DRAIN after row 7 is issued. DRAIN lasts 1 cycle, with mem_rd=0, then goes to ACK.
- ACK, 1 cycle: data_ack=1, rd_ptr=0, data=buf[0]. Then go to SERVE.
- Latency: data_ack is high in the 10th cycle after the edge that samples data_request in IDLE.
- SERVE:
  - data = buf[rd_ptr], combinational from registered storage.
  - byte_rd=1 increments rd_ptr.
  - On the byte_rd that consumes byte 63, go to IDLE; data holds buf[63] until the next ACK.
- Request/data_request rules:
  - data_request is sampled only in IDLE.
  - A request held high through SERVE starts a new fetch on the first IDLE cycle.
  - The controller is expected to drop data_request after the ack. If data_request is still high on the IDLE cycle after SERVE, a new fetch starts anyway.
- Abort: data_request falling during FETCH or DRAIN aborts the fetch. The block returns to IDLE next cycle with mem_rd=0, no data_ack, and buffer contents undefined-but-stable.
- byte_rd outside SERVE is ignored. byte_rd in the ACK cycle is also ignored.
- rd_ptr is 6 bits and never wraps within SERVE; the SERVE exit is taken at rd_ptr=63 with byte_rd=1.
- Asserting rst_n low mid-operation returns to the reset state immediately; no partial ack is issued.
- busy=1 in FETCH, DRAIN, ACK and SERVE.

Optional Feature:
- Macro: LCD_PAGE_BUF_INVERT_EN.
- Defined: captured row data is inverted before transposition, so buf[c][r] = ~mem_rdata[c]. This gives a negative image; timing is unchanged.
- Undefined: no inversion, buf[c][r] = mem_rdata[c].

Test Plan:
- Reset: assert rst_n=0 mid-SERVE, then release → data_ack=0, data=8'h00, busy=0, state IDLE, no mem_rd.
- Basic strip:
  - Stimulus: addr=7'h05; memory row r at mem_addr {7'h05,r} = 64'h1 << r; request held.
  - mem_addr sequence: 0x028..0x02F.
  - data_ack: 10 cycles after the request is sampled.
  - Bytes: 0x01,0x02,0x04,...,0x80 for columns 0-7, then 0x00 for columns 8-63.
- All-ones row 3 only: mem_rdata=64'hFFFF_FFFF_FFFF_FFFF for r=3, else 0 → all 64 bytes = 8'h08; with LCD_PAGE_BUF_INVERT_EN all bytes = 8'hF7.
- Back-to-back: controller-style loop, request → ack → 64 byte_rd at every 2nd cycle → next request with page+1, for 8 pages → 512 bytes correct, exactly 8 acks, no byte skipped or repeated.
- Abort: drop data_request in FETCH cycle 4 → mem_rd=0 next cycle, no data_ack, busy=0; a new request then completes normally.
- Boundary: byte_rd held high continuously through SERVE → exits after exactly 64 strobes, data=buf[63] held. Extra byte_rd pulses in IDLE or ACK → ignored, rd_ptr starts at 0 on the next strip.

Source files
------------

// File: rtl/lcd_page_buf.sv
// Strip fetcher/transposer for the LCD data request/ack handshake: reads 8 image rows, serves 64 column bytes.
// Optional macro LCD_PAGE_BUF_INVERT_EN stores the negative image (rows inverted before transposition).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for data_request; data holds last served byte
// S_FETCH | issuing row reads 0..7, capturing each row one cycle later
// S_DRAIN | capturing row 7, no read issued
// S_ACK   | one-cycle data_ack, byte 0 on data
// S_SERVE | data = column byte at rd_ptr, advanced by byte_rd
module lcd_page_buf #(
  parameter int COLS   = 64,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_request,
  input  logic [6:0]        addr,
  input  logic              byte_rd,
  output logic              data_ack,
  output logic [7:0]        data,
  output logic              busy,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [COLS-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ACK,
    S_SERVE
  } state_t;

  state_t              state_q;
  logic [6:0]          addr_q;
  logic [2:0]          row_cnt_q;
  logic [2:0]          cap_row_q;
  logic                cap_q;
  logic [5:0]          rd_ptr_q;
  logic [7:0]          pix_q [COLS];
  logic [7:0]          hold_q;
  logic                ack_q;
  logic                busy_q;
  logic                mem_rd_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [COLS-1:0]     row_in;

`ifdef LCD_PAGE_BUF_INVERT_EN
  assign row_in = ~mem_rdata;
`else
  assign row_in = mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      row_cnt_q  <= '0;
      cap_row_q  <= '0;
      cap_q      <= 1'b0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      for (int c = 0; c < COLS; c++) pix_q[c] <= '0;
    end else begin
      ack_q <= 1'b0;
      cap_q <= 1'b0;
      // Row issued last cycle is on mem_rdata now; scatter it across the column bytes.
      if (cap_q) begin
        for (int c = 0; c < COLS; c++) pix_q[c][cap_row_q] <= row_in[c];
      end
      case (state_q)
        S_IDLE: begin
          if (data_request) begin
            addr_q     <= addr;
            row_cnt_q  <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= MEM_AW'({addr, 3'd0});
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!data_request) begin
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cap_q     <= 1'b1;
            cap_row_q <= row_cnt_q;
            row_cnt_q <= row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) begin
              mem_rd_q <= 1'b0;
              state_q  <= S_DRAIN;
            end else begin
              mem_addr_q <= MEM_AW'({addr_q, row_cnt_q + 3'd1});
            end
          end
        end
        S_DRAIN: begin
          if (!data_request) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ack_q    <= 1'b1;
            rd_ptr_q <= '0;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          state_q <= S_SERVE;
        end
        S_SERVE: begin
          if (byte_rd) begin
            if (rd_ptr_q == 6'(COLS - 1)) begin
              hold_q  <= pix_q[COLS-1];
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + 6'd1;
            end
          end
        end
        default: begin
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Outside ACK/SERVE the buffer may be refilling, so the last served byte is held separately.
  assign data     = (state_q == S_ACK || state_q == S_SERVE) ? pix_q[rd_ptr_q] : hold_q;
  assign data_ack = ack_q;
  assign busy     = busy_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_lcd_page_buf.sv
// Directed bench for lcd_page_buf: synchronous image memory model, handshake latency, byte order, abort and reset.
module tb_lcd_page_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_request = 1'b0;
  logic [6:0]  addr = '0;
  logic        byte_rd = 1'b0;
  logic        data_ack;
  logic [7:0]  data;
  logic        busy;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [63:0] mem_rdata = '0;

  logic [63:0] mem [1024];
  logic [7:0]  exp_b [64];
  int          tests = 0;
  int          fails = 0;
  int          ack_cnt = 0;
  int          ack_base;

  lcd_page_buf #(.COLS(64), .MEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .data_request(data_request), .addr(addr),
    .byte_rd(byte_rd), .data_ack(data_ack), .data(data), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  always @(negedge clk) if (data_ack) ack_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] inv8(input logic [7:0] b);
`ifdef LCD_PAGE_BUF_INVERT_EN
    return ~b;
`else
    return b;
`endif
  endfunction

  task automatic fill_basic(input logic [6:0] a);
    for (int r = 0; r < 8; r++) mem[{a, 3'(r)}] = 64'h1 << r;
    for (int c = 0; c < 64; c++) exp_b[c] = inv8((c < 8) ? 8'(1 << c) : 8'h00);
  endtask

  task automatic fill_random(input logic [6:0] a);
    logic [7:0] b;
    for (int r = 0; r < 8; r++) mem[{a, 3'(r)}] = {$urandom, $urandom};
    for (int c = 0; c < 64; c++) begin
      for (int r = 0; r < 8; r++) b[r] = mem[{a, 3'(r)}][c];
      exp_b[c] = inv8(b);
    end
  endtask

  // Raises the request and checks the 8 row reads, the drain cycle and the ack cycle.
  task automatic request_strip(input logic [6:0] a);
    addr = a;
    data_request = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("fetch_mem_rd", mem_rd, 1'b1);
        chk("fetch_mem_addr", mem_addr, {a, 3'(k - 1)});
        chk("fetch_no_ack", data_ack, 1'b0);
        chk("fetch_busy", busy, 1'b1);
      end else if (k == 9) begin
        chk("drain_mem_rd", mem_rd, 1'b0);
        chk("drain_no_ack", data_ack, 1'b0);
      end else begin
        chk("ack_latency", data_ack, 1'b1);
        chk("ack_byte0", data, exp_b[0]);
      end
    end
    data_request = 1'b0;
  endtask

  // Called at the ack negedge; strobes byte_rd every second cycle.
  task automatic serve_strip();
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      chk("serve_byte", data, exp_b[i]);
      chk("serve_busy", busy, 1'b1);
      chk("serve_no_ack", data_ack, 1'b0);
      byte_rd = 1'b1;
      @(negedge clk);
      byte_rd = 1'b0;
      if (i < 63) @(negedge clk);
    end
    chk("serve_exit_busy", busy, 1'b0);
    chk("serve_exit_data", data, exp_b[63]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", data_ack, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'h000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Basic strip at addr 0x05: diagonal pattern in columns 0..7
    fill_basic(7'h05);
    request_strip(7'h05);
    serve_strip();

    // Row 3 all ones, byte_rd held high from ACK through SERVE
    for (int r = 0; r < 8; r++) mem[{7'h10, 3'(r)}] = (r == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    for (int c = 0; c < 64; c++) exp_b[c] = inv8(8'h08);
    request_strip(7'h10);
    byte_rd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("held_byte", data, exp_b[i]);
      chk("held_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk("held_exit_busy", busy, 1'b0);
    chk("held_exit_data", data, exp_b[63]);
    repeat (3) @(negedge clk);
    chk("held_idle_data", data, exp_b[63]);
    chk("held_idle_busy", busy, 1'b0);
    byte_rd = 1'b0;
    @(negedge clk);

    // Stray byte_rd pulses in IDLE and in the ACK cycle must not move rd_ptr
    fill_random(7'h11);
    byte_rd = 1'b1;
    @(negedge clk);
    byte_rd = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", busy, 1'b0);
    request_strip(7'h11);
    byte_rd = 1'b1;
    serve_strip();

    // Abort in FETCH cycle 4, then a clean retry of the same strip
    fill_random(7'h12);
    ack_base = ack_cnt;
    addr = 7'h12;
    data_request = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_fetch4_mem_rd", mem_rd, 1'b1);
    chk("abort_fetch4_addr", mem_addr, {7'h12, 3'd4});
    data_request = 1'b0;
    @(negedge clk);
    chk("abort_mem_rd", mem_rd, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (12) @(negedge clk);
    chk("abort_no_ack", ack_cnt - ack_base, 0);
    chk("abort_idle_busy", busy, 1'b0);
    request_strip(7'h12);
    serve_strip();

    // Eight consecutive pages of image 2, controller-style
    ack_base = ack_cnt;
    for (int p = 0; p < 8; p++) begin
      fill_random({4'h2, 3'(p)});
      @(negedge clk);
      request_strip({4'h2, 3'(p)});
      serve_strip();
    end
    chk("b2b_ack_count", ack_cnt - ack_base, 8);

    // Reset asserted mid-SERVE
    fill_basic(7'h05);
    request_strip(7'h05);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      byte_rd = 1'b1;
      @(negedge clk);
      byte_rd = 1'b0;
    end
    chk("pre_rst_data", data, exp_b[3]);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", data_ack, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_rd", mem_rd, 1'b0);
    chk("midrst_mem_addr", mem_addr, 10'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_base = ack_cnt;
    repeat (4) @(negedge clk);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_data", data, 8'h00);
    chk("postrst_mem_rd", mem_rd, 1'b0);
    chk("postrst_no_ack", ack_cnt - ack_base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
